// File: rtl/obi_to_wb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// obi_to_wb_pkg : bus widths, FSM state and response entry for the bridge
// Rev 1.0
// ------------------------------------------------------------------
package obi_to_wb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int RESP_W = DATA_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } resp_t;

  // A termination without ack or err is a timeout, which reports as an error.
  function automatic resp_t make_resp(input logic              we,
                                      input logic              ack,
                                      input logic              err,
                                      input logic [DATA_W-1:0] dat);
    resp_t r;
    r.err   = err || !ack;
    r.rdata = (ack && !err && !we) ? dat : '0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_to_wb_if.sv
`default_nettype none
// ------------------------------------------------------------------
// obi_to_wb_if : OBI slave side and Wishbone master side of the bridge
// Rev 1.0
// ------------------------------------------------------------------
interface obi_to_wb_if;
  import obi_to_wb_pkg::*;

  logic              req_i;
  logic              gnt_o;
  logic [ADDR_W-1:0] addr_i;
  logic              we_i;
  logic [BE_W-1:0]   be_i;
  logic [DATA_W-1:0] wdata_i;
  logic              rvalid_o;
  logic              rready_i;
  logic [DATA_W-1:0] rdata_o;
  logic              err_o;

  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [BE_W-1:0]   wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic              wbm_ack_i;
  logic              wbm_err_i;
  logic [DATA_W-1:0] wbm_dat_i;

  // Bridge view
  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, rready_i,
    input  wbm_ack_i, wbm_err_i, wbm_dat_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  // OBI master plus Wishbone slave environment view
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, rready_i,
    output wbm_ack_i, wbm_err_i, wbm_dat_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

endinterface
`default_nettype wire

// File: rtl/obi_resp_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// obi_resp_fifo : shift-register response FIFO, head entry is always slot 0
// Rev 1.0
// ------------------------------------------------------------------
module obi_resp_fifo
  import obi_to_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = RESP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [IW-1:0]    wr_idx;
  logic             empty_q;

  always_comb begin
    cnt_next = cnt;
    if (push && !pop) begin
      cnt_next = cnt + 1'b1;
    end else if (pop && !push) begin
      cnt_next = cnt - 1'b1;
    end
  end

  // When popping, every entry slides down one slot before the new one lands.
  assign wr_idx = pop ? IW'(cnt - 1'b1) : IW'(cnt);
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = empty_q;
  assign head   = mem[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      cnt     <= '0;
      empty_q <= 1'b1;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem[i] <= mem[i+1];
        end
        mem[DEPTH-1] <= '0;
      end
      if (push) begin
        mem[wr_idx] <= push_data;
      end
      cnt     <= cnt_next;
      empty_q <= (cnt_next == '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/obi_to_wb.sv
`default_nettype none
// ------------------------------------------------------------------
// obi_to_wb : OBI slave to Wishbone B4 classic master bridge, one cycle per grant
// Rev 1.0
// ------------------------------------------------------------------
module obi_to_wb
  import obi_to_wb_pkg::*;
#(
  parameter int RESP_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        wb_rst_i,
  obi_to_wb_if.slave  bus
);

  localparam int             TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state;
  logic              cyc;
  logic              we;
  logic [BE_W-1:0]   sel;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat;
  logic [TW-1:0]     tmo_cnt;

  logic              full;
  logic              empty;
  logic              tmo_hit;
  logic              term;
  logic              pop;
  resp_t             push_resp;
  resp_t             head;

  // Full is taken from the registered count, so a pop this cycle cannot free a grant.
  assign bus.gnt_o = bus.req_i && (state == ST_IDLE) && !full;

  assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  assign term      = (state == ST_BUS) && (bus.wbm_ack_i || bus.wbm_err_i || tmo_hit);
  assign pop       = !empty && bus.rready_i;
  assign push_resp = make_resp(we, bus.wbm_ack_i, bus.wbm_err_i, bus.wbm_dat_i);

  always_ff @(posedge clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= ST_IDLE;
      cyc     <= 1'b0;
      we      <= 1'b0;
      sel     <= '0;
      adr     <= '0;
      dat     <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.gnt_o) begin
            adr     <= bus.addr_i;
            we      <= bus.we_i;
            sel     <= bus.be_i;
            dat     <= bus.wdata_i;
            cyc     <= 1'b1;
            tmo_cnt <= '0;
            state   <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (term) begin
            cyc   <= 1'b0;
            state <= ST_IDLE;
          end else if (TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          cyc   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wbm_cyc_o = cyc;
  assign bus.wbm_stb_o = cyc;
  assign bus.wbm_we_o  = we;
  assign bus.wbm_sel_o = sel;
  assign bus.wbm_adr_o = adr;
  assign bus.wbm_dat_o = dat;

  obi_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (RESP_W)
  ) u_resp_fifo (
    .clk       (clk_i),
    .rst       (wb_rst_i),
    .push      (term),
    .pop       (pop),
    .push_data (push_resp),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign bus.rvalid_o = !empty;
  assign bus.rdata_o  = head.rdata;
  assign bus.err_o    = head.err;

endmodule
`default_nettype wire
